// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_pkg
// Purpose  : Opcode/state types and op-class predicates for the alu_mc unit.
// Revision : 1.0
// ============================================================================
package alu_mc_pkg;

    // Base ops mirror the decoder's alu_op_t; bit 3 marks the M extension.
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SLL    = 4'd1,
        OP_SLT    = 4'd2,
        OP_SLTU   = 4'd3,
        OP_EXOR   = 4'd4,
        OP_SR     = 4'd5,
        OP_OR     = 4'd6,
        OP_AND    = 4'd7,
        OP_MUL    = 4'd8,
        OP_MULH   = 4'd9,
        OP_MULHSU = 4'd10,
        OP_MULHU  = 4'd11,
        OP_DIV    = 4'd12,
        OP_DIVU   = 4'd13,
        OP_REM    = 4'd14,
        OP_REMU   = 4'd15
    } alu_mc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_mc_state_t;

    function automatic logic is_mul(input alu_mc_op_t op);
        return op[3] && !op[2];
    endfunction

    function automatic logic is_div(input alu_mc_op_t op);
        return op[3] && op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Purpose  : Request/result handshake bundle between execute stage and alu_mc.
// Revision : 1.0
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    import alu_mc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_mc_op_t       op;
    logic             sub_arith;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, op, sub_arith, a, b, out_ready,
        input  in_ready, out_valid, res, out_err, busy
    );

    modport slave (
        input  in_valid, op, sub_arith, a, b, out_ready,
        output in_ready, out_valid, res, out_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_mc_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_iter
// Purpose  : One combinational step of shift-add multiply or restoring divide.
// Revision : 1.0
// ============================================================================
module alu_mc_iter #(
    parameter int WIDTH = 32
) (
    input  wire logic             i_div,
    input  wire logic [WIDTH-1:0] i_hi,
    input  wire logic [WIDTH-1:0] i_lo,
    input  wire logic [WIDTH-1:0] i_opnd,
    output logic      [WIDTH-1:0] o_hi,
    output logic      [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        w_shl  = {i_hi, i_lo[WIDTH-1]};
        w_diff = w_shl - {1'b0, i_opnd};
        if (i_div) begin
            // Borrow out of the top bit means the trial subtract must be undone.
            o_hi = w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], ~w_diff[WIDTH]};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle RV32IM execution unit; ALU_MC_DIV_EN enables divider.
// Revision : 1.0
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_mc_if.slave   bus
);
    import alu_mc_pkg::*;

    localparam int             SHW         = $clog2(WIDTH);
    localparam logic [SHW-1:0] c_CNT_LAST  = SHW'(WIDTH - 1);

    alu_mc_state_t    r_state;
    alu_mc_state_t    w_state_nxt;
    alu_mc_op_t       r_op;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_neg_q;
    logic [WIDTH-1:0] r_res;
    logic             r_err;

    logic             w_accept;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_base;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_iter;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;
    logic [2*WIDTH-1:0] w_prod_raw;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0] w_final;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_sh     = bus.b[SHW-1:0];

    always_comb begin
        w_base = '0;
        case (bus.op)
            OP_ADD:  w_base = bus.sub_arith ? (bus.a - bus.b) : (bus.a + bus.b);
            OP_SLL:  w_base = bus.a << w_sh;
            OP_SLT:  w_base = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_base = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_EXOR: w_base = bus.a ^ bus.b;
            OP_SR: begin
                if (bus.sub_arith) w_base = $signed(bus.a) >>> w_sh;
                else               w_base = bus.a >> w_sh;
            end
            OP_OR:   w_base = bus.a | bus.b;
            OP_AND:  w_base = bus.a & bus.b;
            default: w_base = '0;
        endcase
    end

    // MUL takes the low half, which is sign-agnostic, so it runs unsigned.
    assign w_a_sgn = bus.a[WIDTH-1] && (bus.op == OP_MULH || bus.op == OP_MULHSU ||
                                        bus.op == OP_DIV  || bus.op == OP_REM);
    assign w_b_sgn = bus.b[WIDTH-1] && (bus.op == OP_MULH || bus.op == OP_DIV ||
                                        bus.op == OP_REM);
    assign w_a_mag = w_a_sgn ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag = w_b_sgn ? (~bus.b + 1'b1) : bus.b;

`ifdef ALU_MC_DIV_EN
    logic             r_neg_r;
    logic             w_b_zero;
    logic             w_div_ovf;
    logic [WIDTH-1:0] w_div_spec_res;

    assign w_b_zero   = (bus.b == '0);
    assign w_div_ovf  = (bus.op == OP_DIV || bus.op == OP_REM) &&
                        (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    assign w_div_iter = !(w_b_zero || w_div_ovf);
    assign w_div_spec_res = bus.op[1] ? (w_b_zero ? bus.a : '0)
                                      : (w_b_zero ? '1    : bus.a);
`else
    assign w_div_iter = 1'b0;
`endif

    alu_mc_iter #(
        .WIDTH  (WIDTH)
    ) u_iter (
        .i_div  (r_state == ST_DIV),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_opnd (r_opnd),
        .o_hi   (w_hi_n),
        .o_lo   (w_lo_n)
    );

    assign w_prod_raw = {w_hi_n, w_lo_n};
    assign w_prod_s   = r_neg_q ? (~w_prod_raw + 1'b1) : w_prod_raw;

    always_comb begin
        w_final = (r_op[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_DIV_EN
        if (r_state == ST_DIV) begin
            if (r_op[1]) w_final = r_neg_r ? (~w_hi_n + 1'b1) : w_hi_n;
            else         w_final = r_neg_q ? (~w_lo_n + 1'b1) : w_lo_n;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_mul(bus.op))                    w_state_nxt = ST_MUL;
                    else if (is_div(bus.op) && w_div_iter) w_state_nxt = ST_DIV;
                    else                                   w_state_nxt = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == c_CNT_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= OP_ADD;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_neg_q <= 1'b0;
            r_res   <= '0;
            r_err   <= 1'b0;
`ifdef ALU_MC_DIV_EN
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.op;
                        r_cnt <= '0;
                        if (is_mul(bus.op)) begin
                            r_hi    <= '0;
                            r_lo    <= w_b_mag;
                            r_opnd  <= w_a_mag;
                            r_neg_q <= w_a_sgn ^ w_b_sgn;
                        end else if (is_div(bus.op)) begin
`ifdef ALU_MC_DIV_EN
                            r_hi    <= '0;
                            r_lo    <= w_a_mag;
                            r_opnd  <= w_b_mag;
                            r_neg_q <= w_a_sgn ^ w_b_sgn;
                            r_neg_r <= w_a_sgn;
                            r_res   <= w_div_spec_res;
                            r_err   <= 1'b0;
`else
                            r_res   <= '0;
                            r_err   <= 1'b1;
`endif
                        end else begin
                            r_res <= w_base;
                            r_err <= 1'b0;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_hi <= w_hi_n;
                    r_lo <= w_lo_n;
                    if (r_cnt == c_CNT_LAST) begin
                        r_res <= w_final;
                        r_err <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + SHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.res       = r_res;
    assign bus.out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc (both ALU_MC_DIV_EN builds).
// Revision : 1.0
// ============================================================================
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    int   lat;
    logic saw_valid;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic run_op(input alu_mc_op_t op, input logic sub,
                          input logic [31:0] a, input logic [31:0] b, output int l);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.sub_arith = sub;
        bus.a         = a;
        bus.b         = b;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.op        = alu_mc_op_t'(4'($urandom));
        bus.sub_arith = 1'($urandom);
        bus.a         = $urandom;
        bus.b         = $urandom;
        l = 1;
        while (!bus.out_valid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_inrdy"},    {31'b0, bus.in_ready},  32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.sub_arith = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        #12;
        reset = 1'b0;
        #1;
        check("rst_inrdy", {31'b0, bus.in_ready},  32'd1);
        check("rst_vld",   {31'b0, bus.out_valid}, 32'd0);
        check("rst_res",   bus.res,                32'd0);
        check("rst_err",   {31'b0, bus.out_err},   32'd0);
        check("rst_busy",  {31'b0, bus.busy},      32'd0);

        run_op(OP_ADD, 1'b1, 32'd5, 32'd7, lat);
        check("sub_lat", lat, 32'd1);
        check("sub_res", bus.res, 32'hFFFF_FFFE);
        check("sub_err", {31'b0, bus.out_err}, 32'd0);
        handoff("sub");

        run_op(OP_SR, 1'b1, 32'h8000_0000, 32'h21, lat);
        check("sra_res", bus.res, 32'hC000_0000);
        handoff("sra");
        run_op(OP_SR, 1'b0, 32'h8000_0000, 32'h21, lat);
        check("srl_res", bus.res, 32'h4000_0000);
        handoff("srl");
        run_op(OP_SLL, 1'b0, 32'h0000_0001, 32'h3F, lat);
        check("sll_res", bus.res, 32'h8000_0000);
        handoff("sll");
        run_op(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, lat);
        check("slt_res", bus.res, 32'd1);
        handoff("slt");
        run_op(OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, lat);
        check("sltu_res", bus.res, 32'd0);
        handoff("sltu");
        run_op(OP_EXOR, 1'b1, 32'hF0F0_1234, 32'h0FF0_00FF, lat);
        check("xor_res", bus.res, 32'hFF00_12CB);
        handoff("xor");
        run_op(OP_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, lat);
        check("and_res", bus.res, 32'h00F0_0034);
        handoff("and");

        run_op(OP_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mulh_lat", lat, 32'd33);
        check("mulh_res", bus.res, 32'd0);
        handoff("mulh");
        run_op(OP_MULHU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mulhu_res", bus.res, 32'hFFFF_FFFE);
        handoff("mulhu");
        run_op(OP_MULHSU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mulhsu_res", bus.res, 32'hFFFF_FFFF);
        handoff("mulhsu");
        run_op(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mul_res", bus.res, 32'h0000_0001);
        handoff("mul");
        run_op(OP_MULH, 1'b0, 32'hFFFF_FFF9, 32'd3, lat);
        check("mulh_neg", bus.res, 32'hFFFF_FFFF);
        handoff("mulhn");

        // Backpressure with a competing request held on the input side.
        run_op(OP_MUL, 1'b0, 32'd3, 32'd5, lat);
        check("bp_lat", lat, 32'd33);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_res",   bus.res, 32'd15);
            check("bp_inrdy", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        handoff("bp");
        check("bp_res_after", bus.res, 32'd15);

`ifdef ALU_MC_DIV_EN
        run_op(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", lat, 32'd33);
        check("div_res", bus.res, 32'hFFFF_FFFD);
        handoff("div");
        run_op(OP_REM, 1'b0, 32'hFFFF_FFF9, 32'd2, lat);
        check("rem_res", bus.res, 32'hFFFF_FFFF);
        handoff("rem");
        run_op(OP_DIVU, 1'b0, 32'd7, 32'd0, lat);
        check("divu0_lat", lat, 32'd1);
        check("divu0_res", bus.res, 32'hFFFF_FFFF);
        handoff("divu0");
        run_op(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("divovf_lat", lat, 32'd1);
        check("divovf_res", bus.res, 32'h8000_0000);
        handoff("divovf");
        run_op(OP_REM, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("removf_res", bus.res, 32'd0);
        check("removf_err", {31'b0, bus.out_err}, 32'd0);
        handoff("removf");
        run_op(OP_REMU, 1'b0, 32'd100, 32'd7, lat);
        check("remu_res", bus.res, 32'd2);
        handoff("remu");
        run_op(OP_MUL, 1'b0, 32'd3, 32'd5, lat);
        handoff("pre_rst");
`else
        run_op(OP_REMU, 1'b0, 32'd9, 32'd4, lat);
        check("remu_lat", lat, 32'd1);
        check("remu_res", bus.res, 32'd0);
        check("remu_err", {31'b0, bus.out_err}, 32'd1);
        handoff("remu");
        run_op(OP_MULHU, 1'b0, 32'h8000_0000, 32'd6, lat);
        check("mulhu2_res", bus.res, 32'd3);
        check("mulhu2_err", {31'b0, bus.out_err}, 32'd0);
        handoff("mulhu2");
`endif

        // Abort a long op with an asynchronous reset mid-iteration.
        @(negedge clk);
        bus.in_valid = 1'b1;
`ifdef ALU_MC_DIV_EN
        bus.op = OP_DIVU;
`else
        bus.op = OP_MULHU;
`endif
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("abort_busy", {31'b0, bus.busy}, 32'd1);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_vld",   {31'b0, bus.out_valid}, 32'd0);
        check("abort_busy0", {31'b0, bus.busy},      32'd0);
        check("abort_inrdy", {31'b0, bus.in_ready},  32'd1);
        check("abort_res",   bus.res,                32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | bus.out_valid;
        end
        check("abort_stale", {31'b0, saw_valid}, 32'd0);
        run_op(OP_ADD, 1'b0, 32'd1, 32'd1, lat);
        check("post_add_lat", lat, 32'd1);
        check("post_add_res", bus.res, 32'd2);
        handoff("post_add");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised execution unit: the successor to the core's single-cycle ALU. It executes all base RV32I ALU operations plus the RV32M multiply/divide set behind a valid/ready handshake on both sides. Base ops complete in one cycle; multiply and divide iterate one bit per cycle. It sits in the execute stage and stalls the pipeline through `in_ready` / `out_valid`.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 8 and a power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount width; derived, not overridden.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; one clock only.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit accepts the request this cycle.
- `op` in `alu_mc_op_t`: operation code (see Operation).
- `sub_arith` in 1: selects SUB for ADD and SRA for SR; ignored for other ops.
- `a`, `b` in WIDTH: rs1 / rs2-or-immediate operands.
- `out_valid` out 1: `res` valid.
- `out_ready` in 1: consumer takes the result.
- `res` out WIDTH: result.
- `out_err` out 1: op unsupported in this build; qualified by `out_valid`.
- `busy` out 1: state ≠ IDLE.

## Operation
- Ops: ADD, SLL, SLT, SLTU, EXOR, SR, OR, AND (base); MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (M).
- Base ops match RV32I semantics at WIDTH bits. Shifts use `b[SHW-1:0]` only. SLT/SLTU return a zero-extended 1-bit result. Unknown opcode gives `res = 0`.
- Accept: `in_valid && in_ready`. `a`, `b`, `op` and `sub_arith` are latched. Inputs are don't-care after acceptance.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE on accepting a base op, or a div with special case.
  - IDLE → MUL on accepting a mul op.
  - IDLE → DIV on accepting a non-special div op.
  - MUL/DIV → DONE when the iteration counter reaches WIDTH−1.
  - DONE → IDLE when `out_ready`.
- `in_ready = (state == IDLE)`. There is no accept in the same cycle as result hand-off.
- Multiply: signed operands are converted to magnitude. Shift-add runs over WIDTH iterations into a 2·WIDTH product, which is negated at the end if the signs differ. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring shift-subtract on magnitudes over WIDTH iterations. Quotient sign is sign(a) XOR sign(b); remainder sign is sign(a).
- Div special cases:
  - `b == 0`: quotient = all ones, remainder = `a`.
  - Signed overflow (`a = −2^(WIDTH−1)`, `b = −1`): quotient = `a`, remainder = 0.
- `res` and `out_err` are registered and held stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `out_valid = 0`, `res = 0`, `out_err = 0`, `busy = 0`, counter 0. `in_ready` is 1 after reset.
- Latency from the accept edge to `out_valid` high:
  - base ops and div special cases: 1 cycle;
  - mul/div: WIDTH+1 cycles.
- `out_valid` falls the cycle after `out_valid && out_ready`. The next accept is possible that same cycle. Back-to-back throughput for base ops is one result per 2 cycles.
- Reset asserted mid-iteration aborts the op; no `out_valid` is produced for it.
- Counter width is SHW. The counter does not wrap past WIDTH−1; it clears on entering MUL or DIV.

## Configuration
- `ALU_MC_DIV_EN` defined: divider datapath present; DIV, DIVU, REM and REMU behave as above; `out_err` is always 0.
- `ALU_MC_DIV_EN` undefined: no divider logic. Div ops go IDLE → DONE in 1 cycle with `res = 0` and `out_err = 1`. Mul and base ops are unaffected.

## Structure
- `alu_mc_pkg` contains:
  - `alu_mc_op_t` (4-bit enum, base ops encoded identically to the decoder's `alu_op_t` with bit 3 = 0, M ops with bit 3 = 1);
  - `alu_mc_state_t`;
  - helper predicates `is_mul(op)` and `is_div(op)`.
- Sub-module `alu_mc_iter`: one-step shift-add / shift-subtract datapath (combinational, WIDTH-parametrised). It is instantiated once; `alu_mc` owns all registers and the FSM.

## Test plan
- ADD with `sub_arith = 1`, `a = 5`, `b = 7` → `out_valid` 1 cycle after accept, `res = 0xFFFFFFFE`. SR with `sub_arith = 1`, `a = 0x80000000`, `b = 0x21` → `0xC0000000` (shift 1 only).
- MULH `a = 0xFFFFFFFF`, `b = 0xFFFFFFFF` → `res = 0` at cycle 33. MULHU same operands → `0xFFFFFFFE`. MUL → `0x00000001`.
- DIV `a = −7`, `b = 2` → `−3` (`0xFFFFFFFD`); REM → `−1`. DIVU `a = 7`, `b = 0` → `0xFFFFFFFF` at 1-cycle latency. DIV `a = 0x80000000`, `b = −1` → `0x80000000`; REM → 0.
- Backpressure: hold `out_ready = 0` for 10 cycles after a MUL completes → `res` stable, `in_ready = 0`, no second accept. Release → `out_valid` drops next cycle and `in_ready = 1`.
- Assert `reset` at iteration 10 of a DIVU → outputs return to reset values asynchronously and no stale `out_valid` appears. The next ADD `1 + 1` returns 2.
- Build without `ALU_MC_DIV_EN`: REMU `a = 9`, `b = 4` → 1-cycle `out_valid`, `res = 0`, `out_err = 1`. MULHU is still correct.
